// File: rtl/uart_tx_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// Holds the FSM state encoding, the tag prefix and a clog2 helper for index widths.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TAG,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  localparam logic [7:0] TAG_BASE = 8'hA0;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// Producer and transmitter handshake bundle for uart_tx_arb.
// The arbiter uses the slave modport; producers plus the serial block sit on the master side.
interface uart_tx_arb_if #(
  parameter int N = 2
);

  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_byte;
  logic           tx_send;
  logic           tx_busy;

  modport master (
    output req_valid,
    output req_data,
    output tx_busy,
    input  req_ready,
    input  tx_byte,
    input  tx_send
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  tx_busy,
    output req_ready,
    output tx_byte,
    output tx_send
  );

endinterface

// File: rtl/uart_tx_arb_rr_picker.sv
// Combinational round-robin picker: first set request after 'last', wrapping modulo N.
// Kept generic so other shared resources can reuse it.
module rr_picker
  import uart_arb_pkg::*;
#(
  parameter int  N  = 2,
  localparam int IW = clog2(N)
) (
  input  logic [N-1:0]  req_valid,
  input  logic [IW-1:0] last,
  output logic          any,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;

  always_comb begin
    any    = 1'b0;
    onehot = '0;
    idx    = '0;
    cand   = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IW'((int'(last) + i) % N);
      if (!any && req_valid[cand]) begin
        any          = 1'b1;
        onehot[cand] = 1'b1;
        idx          = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter: grant, latch byte, one send pulse, track busy.
// Define UART_ARB_TAG_EN to send a tag byte (8'hA0 | grant_id) ahead of every data byte.
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int  N           = 2,
  parameter int  ACK_TIMEOUT = 64,
  localparam int IW          = clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_arb_if.slave  bus,
  output logic [IW-1:0] grant_id,
  output logic          active,
  output logic          err_timeout
);

  localparam int CW = clog2(ACK_TIMEOUT + 1);

  state_t        state_q, state_d;
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] grant_id_q, grant_id_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          tx_send_q, tx_send_d;
  logic [N-1:0]  req_ready_q, req_ready_d;
  logic          err_timeout_q, err_timeout_d;
  logic          active_q, active_d;
  logic [CW-1:0] cnt_q, cnt_d;
`ifdef UART_ARB_TAG_EN
  logic [7:0]    data_q, data_d;
  logic          phase_q, phase_d;
`endif

  logic          pick_any;
  logic [N-1:0]  pick_onehot;
  logic [IW-1:0] pick_idx;
  logic [7:0]    grant_byte;

  rr_picker #(.N(N)) u_picker (
    .req_valid (bus.req_valid),
    .last      (last_q),
    .any       (pick_any),
    .onehot    (pick_onehot),
    .idx       (pick_idx)
  );

  always_comb begin
    grant_byte = '0;
    for (int i = 0; i < N; i++) begin
      if (pick_onehot[i]) grant_byte = bus.req_data[8*i +: 8];
    end
  end

  // The retry path re-enters ISSUE with tx_byte untouched, so a timed-out byte is resent as-is.
  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    grant_id_d    = grant_id_q;
    tx_byte_d     = tx_byte_q;
    tx_send_d     = 1'b0;
    req_ready_d   = '0;
    err_timeout_d = 1'b0;
    cnt_d         = cnt_q;
`ifdef UART_ARB_TAG_EN
    data_d        = data_q;
    phase_d       = phase_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          req_ready_d = pick_onehot;
          grant_id_d  = pick_idx;
          last_d      = pick_idx;
`ifdef UART_ARB_TAG_EN
          data_d      = grant_byte;
          phase_d     = 1'b0;
          state_d     = TAG;
`else
          tx_byte_d   = grant_byte;
          state_d     = ISSUE;
`endif
        end
      end
`ifdef UART_ARB_TAG_EN
      TAG: begin
        tx_byte_d = TAG_BASE | 8'(grant_id_q);
        state_d   = ISSUE;
      end
`endif
      ISSUE: begin
        if (!bus.tx_busy) begin
          tx_send_d = 1'b1;
          cnt_d     = '0;
          state_d   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CW'(ACK_TIMEOUT)) begin
            err_timeout_d = 1'b1;
            state_d       = ISSUE;
          end
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
`ifdef UART_ARB_TAG_EN
          if (!phase_q) begin
            tx_byte_d = data_q;
            phase_d   = 1'b1;
            state_d   = ISSUE;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    active_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      last_q        <= IW'(N - 1);
      grant_id_q    <= '0;
      tx_byte_q     <= '0;
      tx_send_q     <= 1'b0;
      req_ready_q   <= '0;
      err_timeout_q <= 1'b0;
      active_q      <= 1'b0;
      cnt_q         <= '0;
`ifdef UART_ARB_TAG_EN
      data_q        <= '0;
      phase_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      grant_id_q    <= grant_id_d;
      tx_byte_q     <= tx_byte_d;
      tx_send_q     <= tx_send_d;
      req_ready_q   <= req_ready_d;
      err_timeout_q <= err_timeout_d;
      active_q      <= active_d;
      cnt_q         <= cnt_d;
`ifdef UART_ARB_TAG_EN
      data_q        <= data_d;
      phase_q       <= phase_d;
`endif
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.tx_byte   = tx_byte_q;
  assign bus.tx_send   = tx_send_q;
  assign grant_id      = grant_id_q;
  assign active        = active_q;
  assign err_timeout   = err_timeout_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: a transaction-level model (round-robin order, expected byte
// queue with retry re-queueing) checked every cycle, plus hand-computed directed expectations.
module tb_uart_tx_arb;
  import uart_arb_pkg::*;

  localparam int N   = 2;
  localparam int IW  = clog2(N);
  localparam int ACK = 64;
`ifdef UART_ARB_TAG_EN
  localparam int SPT = 2;
`else
  localparam int SPT = 1;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [IW-1:0] grant_id;
  logic          active;
  logic          err_timeout;

  uart_tx_arb_if #(.N(N)) bus ();

  uart_tx_arb #(.N(N), .ACK_TIMEOUT(ACK)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .grant_id    (grant_id),
    .active      (active),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // serial transmitter model and producer behaviour
  int busy_len;
  int busy_cnt;
  bit frame_busy, force_busy, ignore_next, continuous;

  // transaction-level reference model
  logic [7:0] exp_q[$];
  logic [7:0] last_sent;
  int         m_last, m_gid;
  int         ready_cnt, send_cnt, err_cnt, err_cyc;
  logic [7:0] sent_log[$];
  int         grant_log[$];
  int         send_cyc[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic failNote(input string name, input int actual, input int limit);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got %0d, required within %0d", name, actual, limit);
  endtask

  function automatic int rrPick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic resetModel();
    exp_q.delete();
    sent_log.delete();
    grant_log.delete();
    send_cyc.delete();
    last_sent     = '0;
    m_last        = N - 1;
    m_gid         = 0;
    ready_cnt     = 0;
    send_cnt      = 0;
    err_cnt       = 0;
    err_cyc       = -1;
    frame_busy    = 1'b0;
    busy_cnt      = 0;
    force_busy    = 1'b0;
    ignore_next   = 1'b0;
    continuous    = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.tx_busy   = 1'b0;
  endtask

  task automatic modelCompare();
    int g;
    logic [N-1:0] oh;
    if (reset) return;
    if (bus.req_ready != '0) begin
      g  = rrPick(bus.req_valid, m_last);
      oh = '0;
      if (g >= 0) oh[g] = 1'b1;
      checkOutput("ready_onehot", 32'(bus.req_ready), 32'(oh));
      if (g >= 0) begin
        m_last = g;
        m_gid  = g;
`ifdef UART_ARB_TAG_EN
        exp_q.push_back(8'hA0 | 8'(g));
`endif
        exp_q.push_back(bus.req_data[8*g +: 8]);
      end
      ready_cnt++;
      grant_log.push_back(int'(grant_id));
    end
    checkOutput("grant_id", 32'(grant_id), 32'(m_gid));
    if (bus.tx_send) begin
      if (exp_q.size() == 0) begin
        failNote("unexpected_send", send_cnt + 1, send_cnt);
      end else begin
        checkOutput("send_byte", 32'(bus.tx_byte), 32'(exp_q[0]));
        last_sent = exp_q.pop_front();
      end
      sent_log.push_back(bus.tx_byte);
      send_cyc.push_back(cyc);
      send_cnt++;
    end
    if (err_timeout) begin
      exp_q.push_front(last_sent);
      err_cnt++;
      err_cyc = cyc;
    end
    if (frame_busy) checkOutput("byte_stable", 32'(bus.tx_byte), 32'(last_sent));
  endtask

  task automatic envUpdate();
    if (reset) begin
      frame_busy = 1'b0;
      busy_cnt   = 0;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) frame_busy = 1'b0;
    end else if (bus.tx_send) begin
      if (ignore_next) begin
        ignore_next = 1'b0;
      end else begin
        frame_busy = 1'b1;
        busy_cnt   = busy_len;
      end
    end
    bus.tx_busy = frame_busy | force_busy;
    for (int i = 0; i < N; i++) begin
      if (bus.req_ready[i] && !continuous) bus.req_valid[i] = 1'b0;
    end
  endtask

  task automatic stepCycle();
    @(negedge clk);
    cyc++;
    modelCompare();
    #1;
    envUpdate();
    #1;
  endtask

  task automatic applyStimulus(input int idx, input logic [7:0] data);
    bus.req_data[8*idx +: 8] = data;
    bus.req_valid[idx]       = 1'b1;
  endtask

  task automatic resetDut();
    reset = 1'b1;
    resetModel();
    stepCycle();
    stepCycle();
    reset = 1'b0;
  endtask

  task automatic waitBusyLevel(input bit lvl, input int maxc);
    int n;
    n = 0;
    while (bus.tx_busy != lvl && n < maxc) begin
      stepCycle();
      n++;
    end
    if (bus.tx_busy != lvl) failNote("busy_wait", n, maxc);
  endtask

  task automatic waitSends(input int target, input int maxc);
    int n;
    n = 0;
    while (send_cnt < target && n < maxc) begin
      stepCycle();
      n++;
    end
    if (send_cnt < target) failNote("send_wait", send_cnt, target);
  endtask

  task automatic waitIdle(input int maxc);
    int n;
    n = 0;
    while (!(bus.req_valid == '0 && !active && !bus.tx_busy) && n < maxc) begin
      stepCycle();
      n++;
    end
    if (!(bus.req_valid == '0 && !active && !bus.tx_busy)) failNote("idle_wait", n, maxc);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ready"},   32'(bus.req_ready), 32'd0);
    checkOutput({tag, "_txbyte"},  32'(bus.tx_byte),   32'd0);
    checkOutput({tag, "_send"},    32'(bus.tx_send),   32'd0);
    checkOutput({tag, "_grant"},   32'(grant_id),      32'd0);
    checkOutput({tag, "_active"},  32'(active),        32'd0);
    checkOutput({tag, "_err"},     32'(err_timeout),   32'd0);
  endtask

  logic [7:0] exp_d [4] = '{8'h11, 8'h22, 8'h11, 8'h22};
  int         exp_g [4] = '{0, 1, 0, 1};

  initial begin
    reset = 1'b1;
    resetModel();
    busy_len = 5;

    $display("[TB] reset state");
    stepCycle();
    checkAllZero("rst");
    reset = 1'b0;

    $display("[TB] single requester, long frame");
    resetDut();
    busy_len = 100;
    applyStimulus(0, 8'h55);
    stepCycle();
    checkOutput("t1_ready",  32'(bus.req_ready), 32'h1);
    checkOutput("t1_grant",  32'(grant_id),      32'h0);
    checkOutput("t1_active", 32'(active),        32'h1);
`ifdef UART_ARB_TAG_EN
    stepCycle();
    checkOutput("t1_tag_gap", 32'(bus.tx_send), 32'd0);
    stepCycle();
    checkOutput("t1_send", 32'(bus.tx_send), 32'd1);
    checkOutput("t1_byte", 32'(bus.tx_byte), 32'hA0);
    waitBusyLevel(1'b0, 150);
    stepCycle();
    stepCycle();
    checkOutput("t1_send2", 32'(bus.tx_send), 32'd1);
`else
    stepCycle();
    checkOutput("t1_send", 32'(bus.tx_send), 32'd1);
`endif
    checkOutput("t1_byte_data", 32'(bus.tx_byte), 32'h55);
    waitBusyLevel(1'b0, 150);
    checkOutput("t1_byte_end",    32'(bus.tx_byte), 32'h55);
    checkOutput("t1_active_hold", 32'(active),      32'd1);
    stepCycle();
    checkOutput("t1_active_fall", 32'(active),      32'd0);
    checkOutput("t1_ready_count", 32'(ready_cnt),   32'd1);
    checkOutput("t1_send_count",  32'(send_cnt),    32'(SPT));

    $display("[TB] two requesters, continuous");
    resetDut();
    busy_len   = 5;
    continuous = 1'b1;
    applyStimulus(0, 8'h11);
    applyStimulus(1, 8'h22);
    waitSends(4 * SPT, 400);
    continuous = 1'b0;
    waitIdle(300);
    if (grant_log.size() >= 4 && sent_log.size() >= 4 * SPT) begin
      for (int j = 0; j < 4; j++) begin
        checkOutput("t2_grant_order", 32'(grant_log[j]), 32'(exp_g[j]));
        checkOutput("t2_send_order", 32'(sent_log[SPT*j + SPT - 1]), 32'(exp_d[j]));
`ifdef UART_ARB_TAG_EN
        checkOutput("t2_tag_order", 32'(sent_log[SPT*j]), 32'(8'hA0 | 8'(exp_g[j])));
`endif
      end
    end else begin
      failNote("t2_log_size", sent_log.size(), 4 * SPT);
    end

    $display("[TB] ignored send and retry");
    resetDut();
    busy_len    = 5;
    ignore_next = 1'b1;
    applyStimulus(0, 8'h3C);
    waitSends(2, 200);
    if (send_cyc.size() >= 2) begin
      checkOutput("t3_err_delay", 32'(err_cyc - send_cyc[0]), 32'd64);
      checkOutput("t3_retry_gap", 32'(send_cyc[1] - err_cyc), 32'd1);
`ifdef UART_ARB_TAG_EN
      checkOutput("t3_retry_byte", 32'(sent_log[1]), 32'hA0);
`else
      checkOutput("t3_retry_byte", 32'(sent_log[1]), 32'h3C);
`endif
    end
    waitIdle(300);
    checkOutput("t3_ready_count", 32'(ready_cnt), 32'd1);
    checkOutput("t3_err_count",   32'(err_cnt),   32'd1);

    $display("[TB] busy held at grant");
    resetDut();
    busy_len   = 5;
    force_busy = 1'b1;
    stepCycle();
    applyStimulus(0, 8'h9A);
    stepCycle();
    checkOutput("t4_ready", 32'(bus.req_ready), 32'h1);
    for (int j = 0; j < 8; j++) begin
      stepCycle();
      checkOutput("t4_send_withheld", 32'(bus.tx_send), 32'd0);
    end
    force_busy = 1'b0;
    stepCycle();
    checkOutput("t4_busy_low", 32'(bus.tx_busy), 32'd0);
    stepCycle();
    checkOutput("t4_send_after", 32'(bus.tx_send), 32'd1);
`ifdef UART_ARB_TAG_EN
    checkOutput("t4_byte", 32'(bus.tx_byte), 32'hA0);
`else
    checkOutput("t4_byte", 32'(bus.tx_byte), 32'h9A);
`endif
    waitIdle(300);

    $display("[TB] reset during frame");
    resetDut();
    busy_len = 20;
    applyStimulus(1, 8'hB1);
    waitBusyLevel(1'b1, 30);
    stepCycle();
    stepCycle();
    stepCycle();
    reset = 1'b1;
    resetModel();
    stepCycle();
    checkAllZero("t5");
    reset = 1'b0;
    busy_len = 5;
    applyStimulus(0, 8'h0A);
    applyStimulus(1, 8'h0B);
    stepCycle();
    checkOutput("t5_ready_after", 32'(bus.req_ready), 32'h1);
    checkOutput("t5_grant_after", 32'(grant_id),      32'h0);
    waitIdle(300);
    if (sent_log.size() >= 2 * SPT) begin
      checkOutput("t5_first_data",  32'(sent_log[SPT - 1]),     32'h0A);
      checkOutput("t5_second_data", 32'(sent_log[2 * SPT - 1]), 32'h0B);
    end else begin
      failNote("t5_log_size", sent_log.size(), 2 * SPT);
    end

    $display("[TB] grant atomicity, requester 1 then 0");
    resetDut();
    busy_len = 5;
    applyStimulus(1, 8'h7F);
    stepCycle();
    applyStimulus(0, 8'h33);
    waitIdle(300);
    if (sent_log.size() >= 2 * SPT && grant_log.size() >= 2) begin
      checkOutput("t6_grant0", 32'(grant_log[0]), 32'd1);
      checkOutput("t6_grant1", 32'(grant_log[1]), 32'd0);
`ifdef UART_ARB_TAG_EN
      checkOutput("t6_send0", 32'(sent_log[0]), 32'hA1);
      checkOutput("t6_send1", 32'(sent_log[1]), 32'h7F);
      checkOutput("t6_send2", 32'(sent_log[2]), 32'hA0);
      checkOutput("t6_send3", 32'(sent_log[3]), 32'h33);
`else
      checkOutput("t6_send0", 32'(sent_log[0]), 32'h7F);
      checkOutput("t6_send1", 32'(sent_log[1]), 32'h33);
`endif
    end else begin
      failNote("t6_log_size", sent_log.size(), 2 * SPT);
    end
    checkOutput("t6_ready_count", 32'(ready_cnt), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter and sequencer that shares the single `serial` UART transmitter among N byte producers (sample stream, status, debug). It owns the transmitter's `sbyte`/`send`/`busy` handshake: it picks a requester, latches its byte, and issues exactly one send pulse per byte. It then tracks busy until the frame completes. It sits between the producers and the `serial` instance in `top`.

## Interface
- `N`, 2: number of requesters, from 2 to 16.
- `ACK_TIMEOUT`, 64: clk cycles allowed from the send pulse to busy rising before a retry.
- `clk`  in  1: system clock, 100 MHz.
- `reset`  in  1: asynchronous, active-high.
- `req_valid`  in  N: requester i holds a byte pending; held high until its ready pulse.
- `req_data`  in  8*N: byte i is at bits [8i+7:8i]; stable while valid.
- `req_ready`  out  N: one-cycle pulse; the byte was accepted. One-hot or zero.
- `tx_byte`  out  8: to `serial.sbyte`; stable from the send pulse until busy falls.
- `tx_send`  out  1: to `serial.send`; one-cycle pulse.
- `tx_busy`  in  1: from `serial.busy`.
- `grant_id`  out  clog2(N): index of the current or last granted requester.
- `active`  out  1: high while a transaction is in progress (state != IDLE).
- `err_timeout`  out  1: one-cycle pulse each time the ack timeout expires.

## Operation
- All outputs are registered.
- Reset values:
  - `req_ready=0`, `tx_byte=0`, `tx_send=0`, `grant_id=0`, `active=0`, `err_timeout=0`.
  - State is IDLE.
  - Round-robin pointer `last=N-1`, so requester 0 wins first.
- States:
  - **IDLE**: if any `req_valid` is set, pick the first set bit searching `last+1, last+2, ...` modulo N.
    - Latch its byte into `tx_byte`, pulse `req_ready[g]`, set `grant_id=g` and `last=g`.
    - Go to ISSUE (or TAG when enabled). With no valid bits, stay in IDLE.
  - **ISSUE**: when `tx_busy==0`, pulse `tx_send` and go to WAIT_ACK with the timeout counter cleared. Otherwise wait in ISSUE.
  - **WAIT_ACK**:
    - If `tx_busy==1`, go to WAIT_DONE.
    - Else increment the counter. When it reaches ACK_TIMEOUT, pulse `err_timeout` and return to ISSUE. The same byte is retried indefinitely.
  - **WAIT_DONE**: when `tx_busy==0`, go to IDLE, or to ISSUE for the data phase when tagging.
- Each accepted byte is transmitted exactly once, apart from timeout retries. Bytes are never dropped.
- A requester that deasserts valid before its ready pulse is simply not served. This is legal.
- Asserting reset mid-frame aborts immediately. The serial block resets independently.
- `req_data` is sampled only on the grant edge. Later changes do not affect `tx_byte`.

## Timing
- Valid seen in IDLE at edge k:
  - `req_ready` and `grant_id` are valid in cycle k+1.
  - `tx_send` is high in cycle k+2 if busy is low.
- Busy falling at edge m: the arbiter is in IDLE in cycle m+1. The next grant can be made at edge m+1, so the next `tx_send` comes in cycle m+3.
- Minimum idle gap between consecutive send pulses equals the frame length plus 3 cycles.
- When several requesters are valid continuously, each is served once per N grants.

## Configuration
- Macro `UART_ARB_TAG_EN`.
- **Defined**:
  - Every transaction is two bytes: tag `8'hA0 | grant_id`, then the data byte. The grant is atomic across both bytes.
  - State TAG loads the tag into `tx_byte` and runs ISSUE/WAIT_ACK/WAIT_DONE.
  - WAIT_DONE then loads the latched data byte and re-enters ISSUE.
  - `req_ready` still pulses once, at the grant.
- **Undefined**: single-byte transactions only; TAG state and phase flag are absent.

## Structure
- Package `uart_arb_pkg` holds:
  - the state enum (IDLE, TAG, ISSUE, WAIT_ACK, WAIT_DONE);
  - `TAG_BASE = 8'hA0`;
  - a clog2 function for `grant_id` width.
- Sub-module `rr_picker`: combinational. Takes `req_valid`, `last` and N; returns `any` and the one-hot/index winner. Reused by other shared resources.

## Test plan
- Single requester 0 valid with byte 8'h55, serial model with busy high for 100 cycles:
  - `req_ready[0]` pulses once; `tx_send` pulses once; `tx_byte=8'h55` throughout busy; `active` falls 1 cycle after busy falls.
- N=2, both valid continuously, bytes 8'h11 and 8'h22: send order 11, 22, 11, 22; `grant_id` alternates 0, 1, 0, 1.
- Serial model ignores the first send:
  - `err_timeout` pulses after 64 cycles.
  - The second `tx_send` carries the same byte.
  - Exactly one `req_ready` for the whole transaction.
- `tx_busy` held high externally when a grant occurs: `tx_send` is withheld until busy falls, then pulses within 1 cycle.
- Reset asserted in WAIT_DONE: all outputs are 0 on the next sample; after release, requester 0 is granted first.
- `UART_ARB_TAG_EN` defined, requester 1 sends 8'h7F: two send pulses carrying 8'hA1 then 8'h7F; requester 0's pending byte is not interleaved between them.
